// File: rtl/bar_arbiter_pkg.sv
// Shared definitions for the bar register arbiter: data width, FSM encoding
// and the default lock hold limit.
package bar_arbiter_pkg;

  localparam int BAR_W            = 8;
  localparam int LOCK_MAX_DEFAULT = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bar_arbiter_rr_pick.sv
// Round-robin picker: scans the request vector starting at rr_i and returns
// the first set bit as a one-hot grant plus its index.
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] rr_i,
  output logic [N-1:0]    grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(rr_i) + i) % N;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j[IDXW-1:0];
      end
    end
  end

endmodule

// File: rtl/bar_arbiter.sv
// Round-robin arbiter granting NREQ requesters one registered write per cycle
// into the bar register. Optional lock mode is built with BAR_ARB_LOCK_EN.
module bar_arbiter
  import bar_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*BAR_W-1:0] wdata,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       ack,
  output logic                  bar_we,
  output logic [BAR_W-1:0]      bar_di,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int              IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);

  arb_state_t       state_q, state_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             bar_we_q, bar_we_d;
  logic [BAR_W-1:0] bar_di_q, bar_di_d;
  logic [IDXW-1:0]  rr_q, rr_d;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  pick_oh;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_vld;
  logic [IDXW-1:0]  win_idx;
  logic             grant;

`ifdef BAR_ARB_LOCK_EN
  localparam int            CW      = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);
  logic [IDXW-1:0] owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hold;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // A requester that is being acked this cycle is not eligible again, which
  // limits any single requester to every other cycle outside lock mode.
  always_comb begin
    elig = req & ~ack_q;
`ifdef BAR_ARB_LOCK_EN
    hold = 1'b0;
    if (state_q == LOCKED) begin
      if (cnt_q >= CNT_MAX) elig[owner_q] = 1'b0;
      else                  hold = req[owner_q] & lock[owner_q];
    end
`endif
  end

  rr_pick #(
    .N    (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req_i   (elig),
    .rr_i    (rr_q),
    .grant_o (pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_vld)
  );

  always_comb begin
    state_d  = IDLE;
    ack_d    = '0;
    bar_we_d = 1'b0;
    bar_di_d = bar_di_q;
    rr_d     = rr_q;
    win_idx  = pick_idx;
    grant    = pick_vld;
    ack_d    = pick_oh;
`ifdef BAR_ARB_LOCK_EN
    owner_d = owner_q;
    cnt_d   = '0;
    if (hold) begin
      win_idx        = owner_q;
      grant          = 1'b1;
      ack_d          = '0;
      ack_d[owner_q] = 1'b1;
    end
`endif
    if (grant) begin
      state_d  = WRITE;
      bar_we_d = 1'b1;
      bar_di_d = wdata[win_idx*BAR_W +: BAR_W];
      rr_d     = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
`ifdef BAR_ARB_LOCK_EN
      if (hold) begin
        state_d = LOCKED;
        cnt_d   = cnt_q + 1'b1;
      end else if (lock[win_idx]) begin
        state_d = LOCKED;
        owner_d = win_idx;
        cnt_d   = CW'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      bar_we_q <= 1'b0;
      bar_di_q <= '0;
      rr_q     <= '0;
`ifdef BAR_ARB_LOCK_EN
      owner_q  <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      bar_we_q <= bar_we_d;
      bar_di_q <= bar_di_d;
      rr_q     <= rr_d;
`ifdef BAR_ARB_LOCK_EN
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign bar_we    = bar_we_q;
  assign bar_di    = bar_di_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bar_arbiter.sv
// Directed bench for bar_arbiter: grant latency, round-robin order, ack masking,
// asynchronous reset, idle hold and (with BAR_ARB_LOCK_EN) lock timeout.
module tb_bar_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] wdata;
  logic [NREQ-1:0]   lock;
  logic [NREQ-1:0]   ack;
  logic              bar_we;
  logic [7:0]        bar_di;
  logic              busy;
  logic [1:0]        dbg_state;
  logic [7:0]        bar_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bar_arbiter #(.NREQ(NREQ), .LOCK_MAX(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wdata     (wdata),
    .lock      (lock),
    .ack       (ack),
    .bar_we    (bar_we),
    .bar_di    (bar_di),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // The bar register the arbiter writes into.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      bar_q <= 8'h00;
    else if (bar_we) bar_q <= bar_di;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [3:0] a, input logic we,
                           input logic [7:0] di, input logic bsy);
    check({tag, ".ack"},    32'(ack),    32'(a));
    check({tag, ".bar_we"}, 32'(bar_we), 32'(we));
    check({tag, ".bar_di"}, 32'(bar_di), 32'(di));
    check({tag, ".busy"},   32'(busy),   32'(bsy));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    wdata = '0;

    @(negedge clk);
    check_out("reset", 4'b0000, 1'b0, 8'h00, 1'b0);
    check("reset.state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // Single request: grant one cycle after sampling, bar updated one later.
    req = 4'b0100;
    wdata[23:16] = 8'h5A;
    step();
    check_out("single", 4'b0100, 1'b1, 8'h5A, 1'b1);
    check("single.state", 32'(dbg_state), 32'd1);
    req = 4'b0000;
    step();
    check_out("single_after", 4'b0000, 1'b0, 8'h5A, 1'b0);
    check("single.bar", 32'(bar_q), 32'h5A);

    // Asynchronous reset in the cycle of ack[3].
    req = 4'b1000;
    wdata[31:24] = 8'hC3;
    step();
    check_out("pre_rst", 4'b1000, 1'b1, 8'hC3, 1'b1);
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'b0000, 1'b0, 8'h00, 1'b0);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_out("post_rst", 4'b0000, 1'b0, 8'h00, 1'b0);

    // All four held from rr=0: acks 0,1,2,3,0.
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("rr%0d", i), 4'(1 << (i % 4)), 1'b1, 8'(8'h11 * ((i % 4) + 1)), 1'b1);
    end
    req = 4'b0000;
    step();
    check_out("rr_end", 4'b0000, 1'b0, 8'h11, 1'b0);

    // Same requester held: ack every other cycle (rr now 1).
    req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      step();
      check_out($sformatf("alt%0d", i), (i % 2 == 0) ? 4'b0010 : 4'b0000,
                (i % 2 == 0), 8'h22, (i % 2 == 0));
    end
    req = 4'b0000;
    step();
    check_out("alt_end", 4'b0000, 1'b0, 8'h22, 1'b0);

    // Back-to-back different requesters from rr=2.
    req = 4'b0101;
    step();
    check_out("b2b0", 4'b0100, 1'b1, 8'h33, 1'b1);
    req = 4'b0001;
    step();
    check_out("b2b1", 4'b0001, 1'b1, 8'h11, 1'b1);
    req = 4'b0000;
    step();
    check_out("b2b_end", 4'b0000, 1'b0, 8'h11, 1'b0);

    // Request dropped before being sampled is lost.
    req = 4'b0001;
    #2;
    req = 4'b0000;
    step();
    check_out("dropped", 4'b0000, 1'b0, 8'h11, 1'b0);

    // Idle for 10 cycles: bar_di holds last value.
    for (int i = 0; i < 10; i++) begin
      step();
      check_out($sformatf("idle%0d", i), 4'b0000, 1'b0, 8'h11, 1'b0);
    end

`ifdef BAR_ARB_LOCK_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req  = 4'b0011;
    lock = 4'b0001;
    for (int i = 0; i < 15; i++) begin
      step();
      check_out($sformatf("lock%0d", i), 4'b0001, 1'b1, 8'h11, 1'b1);
      check($sformatf("lock%0d.state", i), 32'(dbg_state), 32'd2);
    end
    step();
    check_out("lock_release", 4'b0010, 1'b1, 8'h22, 1'b1);
    req  = 4'b0000;
    lock = 4'b0000;
    step();
    check_out("lock_end", 4'b0000, 1'b0, 8'h22, 1'b0);
`else
    // Lock input has no effect: requester 0 still alternates (rr now 1).
    req  = 4'b0001;
    lock = 4'b0001;
    step();
    check_out("nolock0", 4'b0001, 1'b1, 8'h11, 1'b1);
    step();
    check_out("nolock1", 4'b0000, 1'b0, 8'h11, 1'b0);
    req  = 4'b0000;
    lock = 4'b0000;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bar_arbiter.md
BAR_ARBITER -- requirements
Module: bar_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the bar register (2..8).
REQ-002 Parameter LOCK_MAX, default 15, max cycles a lock may be held before forced release.
REQ-003 clk  input  1  single clock, all state on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester write request, held until ack.
REQ-006 wdata  input  NREQ x 8  per-requester write data, stable while req high.
REQ-007 lock  input  NREQ  per-requester lock request (used only with BAR_ARB_LOCK_EN).
REQ-008 ack  output  NREQ  one-hot, registered; pulses in the cycle the requester's write is driven.
REQ-009 bar_we  output  1  registered write enable to the bar register.
REQ-010 bar_di  output  8  registered write data to the bar register.
REQ-011 busy  output  1  high when state is not IDLE.

Function
REQ-012 FSM states IDLE, WRITE, LOCKED; reset state IDLE.
REQ-013 At each posedge, eligible requests = req masked by the current ack (req[i] sampled while ack[i]=1 is ignored).
REQ-014 Any eligible request -> winner chosen round-robin starting at pointer rr; next cycle state WRITE, ack[winner]=1, bar_we=1, bar_di=wdata[winner].
REQ-015 Latency: request sampled at edge N -> ack/bar_we high during cycle N+1 -> bar value visible at N+2.
REQ-016 No eligible request -> state IDLE, ack=0, bar_we=0, bar_di holds last value.
REQ-017 After a grant, rr = (winner+1) mod NREQ; rr unchanged when no grant.
REQ-018 Throughput: one write per cycle; back-to-back writes from different requesters allowed; same requester at most every other cycle.
REQ-019 ack is one-hot or zero at all times; exactly one ack per bar_we pulse.
REQ-020 Requester dropping req before ack: request is lost, no ack, no write.

Reset
REQ-021 rst_n low: state IDLE, ack=0, bar_we=0, bar_di=8'h00, rr=0, lock owner cleared, lock counter 0, immediately (asynchronously).
REQ-022 Reset during WRITE or LOCKED aborts the transaction; no ack is issued for it after release.
REQ-023 First grant possible at the first posedge after rst_n deasserts.

Configuration
REQ-024 Macro BAR_ARB_LOCK_EN defined: a requester granted with lock[i]=1 enters LOCKED as owner; only the owner is eligible (REQ-013 mask ignored for owner, allowing writes every cycle).
REQ-025 LOCKED exits to arbitration when owner drops lock, or lock counter reaches LOCK_MAX (forced release, owner excluded from the next arbitration); counter clears on exit.
REQ-026 Macro undefined: lock input ignored, LOCKED state and counter not built.

Structure
REQ-027 Package definitions holds BAR_W=8, arb_state_t enum (IDLE, WRITE, LOCKED), and LOCK_MAX default.
REQ-028 One combinational sub-module rr_pick (request vector + rr pointer -> one-hot winner, valid).

Verification
REQ-029 Single req[2]=1, wdata[2]=8'h5A -> next cycle ack[2]=1, bar_we=1, bar_di=8'h5A; bar reads 8'h5A one cycle later.
REQ-030 req=4'b1111 held continuously with rr=0 -> acks in order 0,1,2,3,0; one bar_we per cycle.
REQ-031 req[1] held high after ack, others idle -> ack[1] every other cycle, never two consecutive.
REQ-032 rst_n low in cycle of ack[3] -> ack, bar_we drop immediately, bar_di=8'h00, rr=0.
REQ-033 BAR_ARB_LOCK_EN: req[0]+lock[0] held, req[1] high -> ack[0] each cycle for 15 cycles, then forced release, ack[1] next.
REQ-034 All req low for 10 cycles -> bar_we=0, busy=0, bar_di unchanged throughout.
